// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, byte-enable masks.
package lsu_pkg;

  localparam logic [2:0] Funct3B  = 3'd0;
  localparam logic [2:0] Funct3H  = 3'd1;
  localparam logic [2:0] Funct3W  = 3'd2;
  localparam logic [2:0] Funct3Bu = 3'd4;
  localparam logic [2:0] Funct3Hu = 3'd5;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, load extraction and
// extension, and illegal/misaligned detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic        illegal;
  logic        misaligned;
  logic [15:0] lane;

  assign lane = 16'(rdata_i >> {off_i, 3'b000});

  always_comb begin
    if (we_i) begin
      illegal = (funct3_i > Funct3W);
    end else begin
      illegal = !(funct3_i inside {Funct3B, Funct3H, Funct3W, Funct3Bu, Funct3Hu});
    end
    case (funct3_i[1:0])
      2'b01:   misaligned = off_i[0];
      2'b10:   misaligned = (off_i != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign fault_o = illegal | misaligned;

  always_comb begin
    be_o = 4'b0000;
    if (we_i) begin
      case (funct3_i)
        Funct3B: be_o = BeByte << off_i;
        Funct3H: be_o = BeHalf << off_i;
        Funct3W: be_o = BeWord;
        default: be_o = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (funct3_i)
      Funct3B: wdata_o = {4{wdata_i[7:0]}};
      Funct3H: wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    case (funct3_i)
      Funct3B:  rdata_o = {{24{lane[7]}}, lane[7:0]};
      Funct3H:  rdata_o = {{16{lane[15]}}, lane};
      Funct3W:  rdata_o = rdata_i;
      Funct3Bu: rdata_o = {24'b0, lane[7:0]};
      Funct3Hu: rdata_o = {16'b0, lane};
      default:  rdata_o = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP handshake to a word-wide memory port.
// Define LSU_TIMEOUT_EN to fault an ACCESS that waits TIMEOUT cycles without mem_ack.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        rsp_valid_q;
  logic        rsp_fault_q;
  logic [31:0] rsp_rdata_q;

  logic        idle;
  logic        al_we;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_fault;

  assign idle = (state_q == StIdle);

  // In IDLE the aligner judges the incoming request; afterwards it decodes the held one.
  assign al_we     = idle ? req_we_i          : we_q;
  assign al_funct3 = idle ? req_funct3_i      : funct3_q;
  assign al_off    = idle ? req_addr_i[1:0]   : off_q;

  lsu_align u_align (
    .we_i     (al_we),
    .funct3_i (al_funct3),
    .off_i    (al_off),
    .wdata_i  (req_wdata_i),
    .rdata_i  (mem_rdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata),
    .fault_o  (al_fault)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      off_q       <= 2'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
      mem_be_q    <= 4'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= 8'b0;
`endif
    end else begin
      // Response fields are single-cycle strobes unless set below.
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            off_q    <= req_addr_i[1:0];
            if (al_fault) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
            end else begin
              state_q     <= StAccess;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_wdata_q <= al_wdata;
              mem_be_q    <= al_be;
`ifdef LSU_TIMEOUT_EN
              tmo_q       <= 8'b0;
`endif
            end
          end
        end
        StAccess: begin
          if (mem_ack_i) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? 32'b0 : al_rdata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_q == TmoLast) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = idle;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_fault_o = rsp_fault_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed and randomized checks of lsu_unit against a behavioural load/store model.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_rdata;
  logic [31:0] got_wdata;
  logic [31:0] got_addr;
  logic [31:0] got_be;

  lsu_unit #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_fault_o  (rsp_fault),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, lanes.
  function automatic int unsigned m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (we) legal = (f3 == 0 || f3 == 1 || f3 == 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return !legal || ((a % m_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    if (!we) return 32'd0;
    mask = ((1 << m_size(f3)) - 1) << (a % 4);
    return mask & 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int unsigned nb;
    nb = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    longint unsigned v;
    longint unsigned mask;
    int unsigned nbits;
    nbits = 8 * m_size(f3);
    mask  = (64'd1 << nbits) - 1;
    v     = (longint'(w) >> (8 * (a % 4))) & mask;
    if (f3 < 4 && nbits < 32 && v[nbits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One complete transaction; drives at posedge+1, samples at posedge+1.
  task automatic do_req(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned dly);
    bit flt;
    flt = m_fault(we, f3, a);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    if (flt) begin
      check({tag, ".fvalid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".ffault"}, {31'd0, rsp_fault}, 32'd1);
      check({tag, ".frdata"}, rsp_rdata, 32'd0);
      check({tag, ".fmemreq"}, {31'd0, mem_req}, 32'd0);
      got_rdata = rsp_rdata;
    end else begin
      check({tag, ".memreq"}, {31'd0, mem_req}, 32'd1);
      check({tag, ".memwe"}, {31'd0, mem_we}, {31'd0, we});
      check({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, ".be"}, {28'd0, mem_be}, m_be(we, f3, a));
      if (we) check({tag, ".wdata"}, mem_wdata, m_wdata(f3, wd));
      got_addr  = mem_addr;
      got_be    = {28'd0, mem_be};
      got_wdata = mem_wdata;
      for (int i = 0; i < int'(dly); i++) begin
        @(posedge clk); #1;
        check({tag, ".hold"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".stable"}, mem_addr, {a[31:2], 2'b00});
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".fault"}, {31'd0, rsp_fault}, 32'd0);
      check({tag, ".rdata"}, rsp_rdata, we ? 32'd0 : m_load(f3, a, rd));
      check({tag, ".reqlow"}, {31'd0, mem_req}, 32'd0);
      got_rdata = rsp_rdata;
    end
    @(posedge clk); #1;
    check({tag, ".strobe"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".clrdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.memreq", {31'd0, mem_req}, 32'd0);
    check("rst.memwe", {31'd0, mem_we}, 32'd0);
    check("rst.valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.fault", {31'd0, rsp_fault}, 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.be", {28'd0, mem_be}, 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    do_req("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    check("lw100.val", got_rdata, 32'hDEADBEEF);
    check("lw100.maddr", got_addr, 32'h100);
    do_req("lb103", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1);
    check("lb103.val", got_rdata, 32'hFFFF_FF80);
    do_req("lbu103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lbu103.val", got_rdata, 32'h0000_0080);
    do_req("lh102", 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 1);
    check("lh102.val", got_rdata, 32'hFFFF_80FF);
    do_req("sb202", 1'b1, 3'd0, 32'h202, 32'h12, 32'h0, 1);
    check("sb202.be", got_be, 32'h4);
    check("sb202.wd", got_wdata, 32'h1212_1212);
    check("sb202.maddr", got_addr, 32'h200);
    do_req("sh202", 1'b1, 3'd1, 32'h202, 32'hABCD, 32'h0, 0);
    check("sh202.be", got_be, 32'hC);
    do_req("lw101", 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    do_req("sh103", 1'b1, 3'd1, 32'h103, 32'h0, 32'h0, 0);
    do_req("ld3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
    do_req("sd4", 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);

    // mem_ack outside ACCESS must not produce a response.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack", {31'd0, rsp_valid}, 32'd0);

    // Timeout behaviour.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      check("tmo.hold", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
    end
    check("tmo.hold4", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    check("tmo.reqlow", {31'd0, mem_req}, 32'd0);
    check("tmo.valid", {31'd0, rsp_valid}, 32'd1);
    check("tmo.fault", {31'd0, rsp_fault}, 32'd1);
    @(posedge clk); #1;
`else
    for (int i = 0; i < 20; i++) begin
      check("wait.hold", {31'd0, mem_req}, 32'd1);
      check("wait.novalid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("wait.rdata", rsp_rdata, 32'h1234_5678);
    @(posedge clk); #1;
`endif

    // Reset in the middle of ACCESS.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h400;
    @(posedge clk); #1;
    check("rstmid.memreq", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.drop", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid.noresp", {31'd0, rsp_valid}, 32'd0);
      check("rstmid.noreq", {31'd0, mem_req}, 32'd0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    do_req("after_rst", 1'b0, 3'd5, 32'h502, 32'h0, 32'hC3A5_0000, 1);
    check("after_rst.val", got_rdata, 32'h0000_C3A5);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, ACCESS-state cycle limit before fault (used only with LSU_TIMEOUT_EN).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store.
REQ-005 req_ready  output  1  LSU can accept; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
REQ-008 req_addr  input  32  byte address from ALU address path.
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 rsp_valid  output  1  one-cycle response strobe.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 rsp_fault  output  1  misaligned, illegal funct3 or timeout; valid with rsp_valid.
REQ-013 mem_req  output  1  memory request, held until mem_ack.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word address, bits [1:0] = 0.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables (0 for loads).
REQ-018 mem_ack  input  1  memory completion, one cycle.
REQ-019 mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; accept when req_valid && req_ready, registering we, funct3, addr, wdata.
REQ-021 Accepted legal request: IDLE -> ACCESS; illegal/misaligned: IDLE -> RESP with rsp_fault=1, mem_req never asserted.
REQ-022 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; illegal: load funct3 3/6/7, store funct3 >= 3.
REQ-023 ACCESS: mem_req=1, mem_we/addr/wdata/be stable until the cycle mem_ack=1, then -> RESP; mem_req low in RESP.
REQ-024 mem_ack outside ACCESS is ignored.
REQ-025 Latency: accept in cycle N, mem_req from N+1, ack in cycle M >= N+1 gives rsp_valid in M+1; fault path gives rsp_valid in N+1.
REQ-026 RESP lasts exactly one cycle, then IDLE; no back-pressure on response.
REQ-027 Store be: SB 4'b0001 << addr[1:0], SH 4'b0011 << addr[1:0], SW 4'b1111; wdata byte replicated x4 (SB), half x2 (SH).
REQ-028 Load extraction from mem_rdata lane at addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-029 rsp_rdata registered on mem_ack, held through RESP, 0 otherwise.

Reset
REQ-030 rst_n low: state IDLE, mem_req/mem_we/rsp_valid/rsp_fault 0, mem_addr/mem_wdata/mem_be/rsp_rdata 0, timeout counter 0.
REQ-031 Reset mid-ACCESS drops mem_req immediately and produces no response; requests during reset are not accepted.
REQ-032 First acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro LSU_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle without ack; at TIMEOUT -> RESP with rsp_fault=1, mem_req drops.
REQ-034 LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for mem_ack.

Structure
REQ-035 Package lsu_pkg holds funct3 encodings, FSM state encoding and byte-enable constants.
REQ-036 Sub-module lsu_align (combinational): be/wdata generation, load lane extraction and extension, misalignment detection.

Verification
REQ-037 LW addr 0x100, mem_rdata 0xDEADBEEF, ack 2 cycles after mem_req -> mem_addr 0x100, rsp_rdata 0xDEADBEEF, rsp_fault 0, rsp_valid one cycle.
REQ-038 LB/LBU addr 0x103, mem_rdata 0x80FF_0000 -> 0xFFFF_FF80 / 0x0000_0080; LH addr 0x102 -> 0xFFFF_80FF.
REQ-039 SB addr 0x202 wdata 0x12 -> mem_be 4'b0100, mem_wdata 0x1212_1212, mem_addr 0x200; SH addr 0x202 -> mem_be 4'b1100.
REQ-040 LW addr 0x101, SH addr 0x103, load funct3 3 -> rsp_fault 1 next cycle, mem_req never high.
REQ-041 LSU_TIMEOUT_EN, TIMEOUT 4, no ack -> rsp_fault 1, mem_req low after 4 ACCESS cycles; without macro mem_req stays high.
REQ-042 rst_n low during ACCESS -> mem_req 0 asynchronously, no rsp_valid; next request after release completes normally.
